// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one uart_tx serializer between a handshake and an application requester
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 2,
  parameter int TIMEOUT_BITS = 12,
  parameter int ROUND_ROBIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Enable,
  input  logic       i_Req0,
  input  logic [7:0] i_Byte0,
  output logic       o_Ack0,
  output logic       o_Done0,
  input  logic       i_Req1,
  input  logic [7:0] i_Byte1,
  output logic       o_Ack1,
  output logic       o_Done1,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic [1:0] o_Grant,
  output logic       o_Busy,
  output logic       o_Timeout
);

  localparam int MAX_BITS = (TIMEOUT_BITS > GAP_BITS) ? TIMEOUT_BITS : GAP_BITS;
  localparam int CW       = $clog2(MAX_BITS * CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last1, last1_d;
  logic          ack0_d, ack1_d, done0_d, done1_d, dv_d, busy_d, timeout_d;
  logic [1:0]    grant_d;
  logic [7:0]    byte_d;
  logic          elig0, elig1, pick1;

  // Enable only gates new req1 grants; an in-flight req1 transfer always finishes.
  assign elig0 = i_Req0;
  assign elig1 = i_Req1 & i_Enable;
  assign pick1 = elig1 & (~elig0 | ((ROUND_ROBIN != 0) & ~last1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last1     <= 1'b1;
      o_Ack0    <= 1'b0;
      o_Ack1    <= 1'b0;
      o_Done0   <= 1'b0;
      o_Done1   <= 1'b0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      o_Grant   <= '0;
      o_Busy    <= 1'b0;
      o_Timeout <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      last1     <= last1_d;
      o_Ack0    <= ack0_d;
      o_Ack1    <= ack1_d;
      o_Done0   <= done0_d;
      o_Done1   <= done1_d;
      o_Tx_DV   <= dv_d;
      o_Tx_Byte <= byte_d;
      o_Grant   <= grant_d;
      o_Busy    <= busy_d;
      o_Timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    last1_d   = last1;
    grant_d   = o_Grant;
    byte_d    = o_Tx_Byte;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    dv_d      = 1'b0;
    timeout_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (elig0 | elig1) begin
          last1_d = pick1;
          grant_d = pick1 ? 2'b10 : 2'b01;
          byte_d  = pick1 ? i_Byte1 : i_Byte0;
          ack0_d  = ~pick1;
          ack1_d  = pick1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dv_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as a completed transfer.
        if (i_Tx_Done) begin
          done0_d = o_Grant[0];
          done1_d = o_Grant[1];
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt == TO_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter, fixed-priority and round-robin instances
module tb_uart_tx_arbiter;

  localparam int CPB      = 4;
  localparam int GAPB     = 2;
  localparam int TOB      = 12;
  localparam int TO_CLKS  = TOB * CPB;
  localparam int GAP_CLKS = GAPB * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_Enable = 1'b0;
  logic       i_Req0 = 1'b0;
  logic [7:0] i_Byte0 = 8'h00;
  logic       i_Req1 = 1'b0;
  logic [7:0] i_Byte1 = 8'h00;
  logic       i_Tx_Done = 1'b0;

  logic [1:0] ack0, ack1, done0, done1, dv, busy, tmo;
  logic [1:0] grant [2];
  logic [7:0] txb [2];

  int checks = 0;
  int failures = 0;

  bit         last1 [2];
  logic [7:0] prev_byte [2];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAPB), .TIMEOUT_BITS(TOB), .ROUND_ROBIN(0)) dut_fixed (
    .clk(clk), .reset(reset), .i_Enable(i_Enable),
    .i_Req0(i_Req0), .i_Byte0(i_Byte0), .o_Ack0(ack0[0]), .o_Done0(done0[0]),
    .i_Req1(i_Req1), .i_Byte1(i_Byte1), .o_Ack1(ack1[0]), .o_Done1(done1[0]),
    .o_Tx_DV(dv[0]), .o_Tx_Byte(txb[0]), .i_Tx_Done(i_Tx_Done),
    .o_Grant(grant[0]), .o_Busy(busy[0]), .o_Timeout(tmo[0])
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAPB), .TIMEOUT_BITS(TOB), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .i_Enable(i_Enable),
    .i_Req0(i_Req0), .i_Byte0(i_Byte0), .o_Ack0(ack0[1]), .o_Done0(done0[1]),
    .i_Req1(i_Req1), .i_Byte1(i_Byte1), .o_Ack1(ack1[1]), .o_Done1(done1[1]),
    .o_Tx_DV(dv[1]), .o_Tx_Byte(txb[1]), .i_Tx_Done(i_Tx_Done),
    .o_Grant(grant[1]), .o_Busy(busy[1]), .o_Timeout(tmo[1])
  );

  function automatic logic [16:0] obs_of(input int d);
    return {ack0[d], ack1[d], dv[d], done0[d], done1[d], tmo[d], busy[d], grant[d], txb[d]};
  endfunction

  function automatic logic [16:0] mkvec(input logic a0, input logic a1, input logic v,
                                        input logic d0, input logic d1, input logic t,
                                        input logic b, input logic [1:0] g, input logic [7:0] by);
    return {a0, a1, v, d0, d1, t, b, g, by};
  endfunction

  // Owner choice: req0 beats req1 unless round-robin and req0 was served last.
  function automatic bit pick(input bit e0, input bit e1, input bit rr, input bit l1);
    if (e0 && e1) return rr ? !l1 : 1'b0;
    return e1;
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last1[d] = 1'b1;
      prev_byte[d] = 8'h00;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("%s_d%0d", tag, d), obs_of(d), 17'h0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      for (int d = 0; d < 2; d++)
        check($sformatf("%s_d%0d_c%0d", tag, d, i), obs_of(d),
              mkvec(0, 0, 0, 0, 0, 0, 0, 2'b00, prev_byte[d]));
    end
  endtask

  // Called in the cycle the requests are first presented with both DUTs idle.
  // done_dly: clocks after the Tx_DV cycle at which i_Tx_Done pulses; negative = never.
  task automatic serve(input string tag, input logic [1:0] drop, input int done_dly);
    bit e0, e1, ok_done;
    bit own [2];
    logic [7:0] eb [2];
    logic [1:0] g;
    int endc, idlec;
    for (int d = 0; d < 2; d++)
      check($sformatf("%s_start_d%0d", tag, d), obs_of(d),
            mkvec(0, 0, 0, 0, 0, 0, 0, 2'b00, prev_byte[d]));
    e0 = i_Req0;
    e1 = i_Req1 && i_Enable;
    for (int d = 0; d < 2; d++) begin
      own[d] = pick(e0, e1, d == 1, last1[d]);
      last1[d] = own[d];
      eb[d] = own[d] ? i_Byte1 : i_Byte0;
      prev_byte[d] = eb[d];
    end
    ok_done = (done_dly >= 0) && (done_dly < TO_CLKS);
    endc = ok_done ? done_dly + 3 : TO_CLKS + 2;
    idlec = endc + GAP_CLKS;
    for (int c = 1; c <= idlec; c++) begin
      tick();
      i_Tx_Done = 1'b0;
      for (int d = 0; d < 2; d++) begin
        g = own[d] ? 2'b10 : 2'b01;
        check($sformatf("%s_d%0d_c%0d", tag, d, c), obs_of(d),
              mkvec(c == 1 && !own[d], c == 1 && own[d], c == 2,
                    ok_done && c == endc && !own[d], ok_done && c == endc && own[d],
                    !ok_done && c == endc, c < idlec, (c < idlec) ? g : 2'b00, eb[d]));
      end
      if (c == 1) begin
        if (drop[0]) i_Req0 = 1'b0;
        if (drop[1]) i_Req1 = 1'b0;
      end
      if (done_dly >= 0 && c == done_dly + 2) i_Tx_Done = 1'b1;
    end
    i_Tx_Done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r, dly;
    model_reset();
    do_reset("reset_init");

    // single handshake byte, done 40 clocks after DV
    i_Byte1 = 8'($urandom);
    i_Byte0 = 8'h45;
    i_Req0 = 1'b1;
    serve("t1", 2'b01, 40);

    // simultaneous requests, then both held for back-to-back rounds
    do_reset("reset_t2");
    i_Enable = 1'b1;
    i_Byte0 = 8'h45;
    i_Byte1 = 8'($urandom);
    i_Req0 = 1'b1;
    i_Req1 = 1'b1;
    serve("t2a", 2'b01, int'($urandom_range(0, 30)));
    serve("t2b", 2'b10, int'($urandom_range(0, 30)));
    i_Req0 = 1'b1;
    i_Req1 = 1'b1;
    serve("t2c", 2'b01, int'($urandom_range(0, 30)));
    serve("t2d", 2'b10, int'($urandom_range(0, 30)));
    i_Req0 = 1'b1;
    i_Req1 = 1'b1;
    for (int k = 0; k < 3; k++) serve($sformatf("t2rr%0d", k), 2'b00, int'($urandom_range(0, 20)));
    serve("t2rr3", 2'b11, int'($urandom_range(0, 20)));

    // req1 blocked while disabled, granted the clock after enable rises
    i_Enable = 1'b0;
    i_Byte1 = 8'hA5;
    i_Req1 = 1'b1;
    idle_cycles(100, "t3_blocked");
    i_Enable = 1'b1;
    serve("t3", 2'b10, 20);

    // no done at all: timeout 48 clocks after DV
    i_Byte0 = 8'($urandom);
    i_Req0 = 1'b1;
    serve("t4", 2'b01, -1);

    // reset in the middle of WAIT, then a stale done
    b = 8'($urandom);
    i_Byte0 = b;
    i_Req0 = 1'b1;
    tick();
    for (int d = 0; d < 2; d++)
      check($sformatf("t5_ack_d%0d", d), obs_of(d), mkvec(1, 0, 0, 0, 0, 0, 1, 2'b01, b));
    i_Req0 = 1'b0;
    repeat (11) tick();
    do_reset("t5_reset_wait");
    repeat (3) tick();
    i_Tx_Done = 1'b1;
    tick();
    i_Tx_Done = 1'b0;
    idle_cycles(6, "t5_stale_done");

    // done on the same clock the timeout would fire
    i_Byte1 = 8'($urandom);
    i_Req1 = 1'b1;
    serve("t6", 2'b10, TO_CLKS - 1);

    // randomized rounds
    for (int k = 0; k < 20; k++) begin
      i_Enable = 1'($urandom);
      i_Req0 = 1'($urandom);
      i_Req1 = 1'($urandom);
      i_Byte0 = 8'($urandom);
      i_Byte1 = 8'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) dly = -1;
      else if (r == 1) dly = TO_CLKS - 1;
      else if (r == 2) dly = TO_CLKS + int'($urandom_range(0, 4));
      else dly = int'($urandom_range(0, 45));
      if (i_Req0 || (i_Req1 && i_Enable)) begin
        serve($sformatf("rnd%0d", k), 2'b11, dly);
      end else begin
        idle_cycles(3, $sformatf("rnd%0d_none", k));
        i_Req1 = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
